lcd_hd44780_responder: RTL and testbench

- Synthesizable HD44780-compatible target for the 8-bit character-LCD bus driven by the SOPC LCD Avalon slave (E/RS/RW/D[7:0]).
- Decodes commands and data, keeps a 128-byte DDRAM and a 7-bit address counter (AC), and models the busy flag.
- Answers bus reads and exposes DDRAM through a second read port for a text-overlay renderer or board-less simulation.
- Sits on the LCD pin side, clocked by the system clock. All LCD inputs are treated as asynchronous.

---
 rtl/lcd_hd44780_pkg.sv | 42 ++++
 rtl/lcd_hd44780_responder_sync.sv | 48 ++++
 rtl/lcd_hd44780_responder.sv | 224 ++++++++++++++++++++++
 tb/tb_lcd_hd44780_responder.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_hd44780_pkg.sv
// Shared types and constants for the HD44780-compatible LCD responder.
// Holds instruction classes, DDRAM geometry, counter width and the
// instruction classifier used by the execute stage.
package lcd_hd44780_pkg;

   localparam int AC_W        = 7;
   localparam int DDRAM_DEPTH = 128;
   localparam int CNT_W       = 17;

   localparam logic [7:0] ASCII_SPACE = 8'h20;

   typedef enum logic [2:0] {
      CLR,
      HOME,
      ENTRY,
      DISP,
      SHIFT_FUNC,
      CGRAM,
      DDRAM,
      NOP
   } ins_class_e;

   typedef enum logic {
      FILL_IDLE,
      FILL_RUN
   } fill_state_e;

   // Instruction class is selected by the highest set bit of the opcode.
   function automatic ins_class_e decode_ins(input logic [7:0] op);
      ins_class_e cls;
      if (op[7])               cls = DDRAM;
      else if (op[6])          cls = CGRAM;
      else if (op[5] | op[4])  cls = SHIFT_FUNC;
      else if (op[3])          cls = DISP;
      else if (op[2])          cls = ENTRY;
      else if (op[1])          cls = HOME;
      else if (op[0])          cls = CLR;
      else                     cls = NOP;
      return cls;
   endfunction

endpackage

// File: rtl/lcd_hd44780_responder_sync.sv
// Two-flop synchronizers for the asynchronous LCD pins plus E edge pulses.
// Ports: clk, reset (async, active-high), raw lcd_e/rs/rw/data in;
//        synchronized e_s/rs_s/rw_s/data_s and one-cycle e_rise/e_fall out.
module lcd_bus_sync (
   input  logic       clk,
   input  logic       reset,
   input  logic       lcd_e,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic [7:0] lcd_data,
   output logic       e_s,
   output logic       rs_s,
   output logic       rw_s,
   output logic [7:0] data_s,
   output logic       e_rise,
   output logic       e_fall
);

   logic [10:0] meta_q, meta_d;
   logic [10:0] sync_q, sync_d;
   logic        e_prev_q, e_prev_d;

   always_comb begin
      meta_d   = {lcd_e, lcd_rs, lcd_rw, lcd_data};
      sync_d   = meta_q;
      e_prev_d = sync_q[10];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q   <= '0;
         sync_q   <= '0;
         e_prev_q <= 1'b0;
      end else begin
         meta_q   <= meta_d;
         sync_q   <= sync_d;
         e_prev_q <= e_prev_d;
      end
   end

   assign e_s    = sync_q[10];
   assign rs_s   = sync_q[9];
   assign rw_s   = sync_q[8];
   assign data_s = sync_q[7:0];
   assign e_rise = e_s & ~e_prev_q;
   assign e_fall = ~e_s & e_prev_q;

endmodule

// File: rtl/lcd_hd44780_responder.sv
// HD44780-compatible LCD target: decodes bus writes, keeps a 128-byte DDRAM
// and address counter, models the busy flag, answers bus reads and offers a
// registered overlay read port.
// Ports: clk, reset (async, active-high), LCD_E/LCD_RS/LCD_RW/lcd_data_in
//        from the bus master, lcd_data_out/lcd_data_oe to the pads,
//        disp_addr/disp_char overlay port, display_on, busy.
// Optional: define LCD_PROTOCOL_CHECK_EN to add the sticky protocol_err output.
//
// state     | meaning
// FILL_IDLE | no clear in progress
// FILL_RUN  | writing spaces to DDRAM[0..127], one byte per cycle
module lcd_hd44780_responder
   import lcd_hd44780_pkg::*;
#(
   parameter int BUSY_CYCLES  = 2000,
   parameter int CLEAR_CYCLES = 76500,
   parameter int MIN_E_CYCLES = 12
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       LCD_E,
   input  logic       LCD_RS,
   input  logic       LCD_RW,
   input  logic [7:0] lcd_data_in,
   output logic [7:0] lcd_data_out,
   output logic       lcd_data_oe,
   input  logic [6:0] disp_addr,
   output logic [7:0] disp_char,
   output logic       display_on,
   output logic       busy
`ifdef LCD_PROTOCOL_CHECK_EN
   ,
   output logic       protocol_err
`endif
);

   logic            e_s, rs_s, rw_s, e_rise, e_fall;
   logic [7:0]      data_s;

   lcd_bus_sync u_sync (
      .clk      (clk),
      .reset    (reset),
      .lcd_e    (LCD_E),
      .lcd_rs   (LCD_RS),
      .lcd_rw   (LCD_RW),
      .lcd_data (lcd_data_in),
      .e_s      (e_s),
      .rs_s     (rs_s),
      .rw_s     (rw_s),
      .data_s   (data_s),
      .e_rise   (e_rise),
      .e_fall   (e_fall)
   );

   logic [7:0]      ddram_mem [DDRAM_DEPTH];
   logic            mem_we;
   logic [AC_W-1:0] mem_waddr;
   logic [7:0]      mem_wdata;

   logic            cap_rs_q, cap_rs_d, cap_rw_q, cap_rw_d;
   logic [7:0]      cap_data_q, cap_data_d;
   logic            exec_q, exec_d;
   logic            rd_q, rd_d, rd_rs_q, rd_rs_d;
   logic [AC_W-1:0] ac_q, ac_d, ac_step;
   logic            id_q, id_d;
   logic            disp_on_q, disp_on_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   fill_state_e     fill_state_q, fill_state_d;
   logic [AC_W-1:0] fill_addr_q, fill_addr_d;
   logic [7:0]      data_out_q, data_out_d;
   logic [7:0]      disp_char_q, disp_char_d;
   logic            bf;
`ifdef LCD_PROTOCOL_CHECK_EN
   localparam logic [7:0] MIN_E = 8'(MIN_E_CYCLES);
   logic [7:0]      e_width_q, e_width_d;
   logic            err_q, err_d;
`endif

   always_comb begin
      cap_rs_d     = cap_rs_q;
      cap_rw_d     = cap_rw_q;
      cap_data_d   = cap_data_q;
      rd_d         = rd_q;
      rd_rs_d      = rd_rs_q;
      ac_d         = ac_q;
      id_d         = id_q;
      disp_on_d    = disp_on_q;
      cnt_d        = cnt_q;
      fill_state_d = fill_state_q;
      fill_addr_d  = fill_addr_q;
      data_out_d   = data_out_q;
      disp_char_d  = ddram_mem[disp_addr];
      mem_we       = 1'b0;
      mem_waddr    = ac_q;
      mem_wdata    = cap_data_q;

      // BF covers both the timer and the fill; the fill normally ends first.
      bf      = (cnt_q != '0) || (fill_state_q == FILL_RUN);
      ac_step = id_q ? ac_q + 7'd1 : ac_q - 7'd1;
      exec_d  = e_fall & ~cap_rw_q;

      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;

      if (e_s) begin
         cap_rs_d   = rs_s;
         cap_rw_d   = rw_s;
         cap_data_d = data_s;
      end

      // Read direction is latched at E rise and held until E falls.
      if (e_rise) begin
         rd_d    = rw_s;
         rd_rs_d = rs_s;
         if (rw_s) data_out_d = rs_s ? ddram_mem[ac_q] : {bf, ac_q};
      end
      if (e_fall) begin
         rd_d = 1'b0;
         if (rd_q && rd_rs_q) ac_d = ac_step;
      end

      if (fill_state_q == FILL_RUN) begin
         mem_we      = 1'b1;
         mem_waddr   = fill_addr_q;
         mem_wdata   = ASCII_SPACE;
         fill_addr_d = fill_addr_q + 7'd1;
         if (fill_addr_q == 7'h7F) fill_state_d = FILL_IDLE;
      end

      // A busy write is dropped; the fill cannot collide with this port.
      if (exec_q && !bf) begin
         cnt_d = CNT_W'(BUSY_CYCLES);
         if (cap_rs_q) begin
            mem_we    = 1'b1;
            mem_waddr = ac_q;
            mem_wdata = cap_data_q;
            ac_d      = ac_step;
         end else begin
            case (decode_ins(cap_data_q))
               CLR: begin
                  fill_state_d = FILL_RUN;
                  fill_addr_d  = '0;
                  ac_d         = '0;
                  id_d         = 1'b1;
                  cnt_d        = CNT_W'(CLEAR_CYCLES);
               end
               HOME: begin
                  ac_d  = '0;
                  cnt_d = CNT_W'(CLEAR_CYCLES);
               end
               ENTRY:   id_d      = cap_data_q[1];
               DISP:    disp_on_d = cap_data_q[2];
               DDRAM:   ac_d      = cap_data_q[6:0];
               default: ;
            endcase
         end
      end

`ifdef LCD_PROTOCOL_CHECK_EN
      e_width_d = e_width_q;
      err_d     = err_q;
      if (e_rise) e_width_d = 8'd1;
      else if (e_s && e_width_q != 8'hFF) e_width_d = e_width_q + 8'd1;
      if (e_fall && e_width_q < MIN_E) err_d = 1'b1;
      if (exec_q && bf) err_d = 1'b1;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cap_rs_q     <= 1'b0;
         cap_rw_q     <= 1'b0;
         cap_data_q   <= '0;
         exec_q       <= 1'b0;
         rd_q         <= 1'b0;
         rd_rs_q      <= 1'b0;
         ac_q         <= '0;
         id_q         <= 1'b1;
         disp_on_q    <= 1'b0;
         cnt_q        <= '0;
         fill_state_q <= FILL_IDLE;
         fill_addr_q  <= '0;
         data_out_q   <= '0;
         disp_char_q  <= '0;
`ifdef LCD_PROTOCOL_CHECK_EN
         e_width_q    <= '0;
         err_q        <= 1'b0;
`endif
      end else begin
         cap_rs_q     <= cap_rs_d;
         cap_rw_q     <= cap_rw_d;
         cap_data_q   <= cap_data_d;
         exec_q       <= exec_d;
         rd_q         <= rd_d;
         rd_rs_q      <= rd_rs_d;
         ac_q         <= ac_d;
         id_q         <= id_d;
         disp_on_q    <= disp_on_d;
         cnt_q        <= cnt_d;
         fill_state_q <= fill_state_d;
         fill_addr_q  <= fill_addr_d;
         data_out_q   <= data_out_d;
         disp_char_q  <= disp_char_d;
`ifdef LCD_PROTOCOL_CHECK_EN
         e_width_q    <= e_width_d;
         err_q        <= err_d;
`endif
      end
   end

   // DDRAM contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) ddram_mem[mem_waddr] <= mem_wdata;
   end

   assign lcd_data_out = data_out_q;
   assign lcd_data_oe  = rd_q;
   assign disp_char    = disp_char_q;
   assign display_on   = disp_on_q;
   assign busy         = bf;
`ifdef LCD_PROTOCOL_CHECK_EN
   assign protocol_err = err_q;
`endif

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
module tb_lcd_hd44780_responder;

   localparam int BUSY_C  = 60;
   localparam int CLEAR_C = 400;
   localparam int MIN_E   = 12;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
   logic [7:0] lcd_data_in = 8'h00;
   logic [7:0] lcd_data_out;
   logic       lcd_data_oe;
   logic [6:0] disp_addr = 7'h00;
   logic [7:0] disp_char;
   logic       display_on;
   logic       busy;
`ifdef LCD_PROTOCOL_CHECK_EN
   logic       protocol_err;
`endif

   int checks = 0;
   int errors = 0;
   int busy_cnt = 0;

   logic [7:0] m_ddram [128];
   logic [6:0] m_ac;
   bit         m_id;
   bit         m_disp;

   lcd_hd44780_responder #(
      .BUSY_CYCLES  (BUSY_C),
      .CLEAR_CYCLES (CLEAR_C),
      .MIN_E_CYCLES (MIN_E)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .LCD_E        (lcd_e),
      .LCD_RS       (lcd_rs),
      .LCD_RW       (lcd_rw),
      .lcd_data_in  (lcd_data_in),
      .lcd_data_out (lcd_data_out),
      .lcd_data_oe  (lcd_data_oe),
      .disp_addr    (disp_addr),
      .disp_char    (disp_char),
      .display_on   (display_on),
      .busy         (busy)
`ifdef LCD_PROTOCOL_CHECK_EN
      ,
      .protocol_err (protocol_err)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (busy === 1'b1) busy_cnt++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   function automatic logic [6:0] m_next(input logic [6:0] a);
      return 7'((int'(a) + (m_id ? 1 : 127)) % 128);
   endfunction

   // Reference behaviour of an accepted write.
   function automatic void model_write(input bit rs, input logic [7:0] d);
      if (rs) begin
         m_ddram[m_ac] = d;
         m_ac = m_next(m_ac);
      end else if (d == 8'h01) begin
         for (int i = 0; i < 128; i++) m_ddram[i] = 8'h20;
         m_ac = 7'h00;
         m_id = 1'b1;
      end else if (d >= 8'h02 && d <= 8'h03) m_ac = 7'h00;
      else if (d >= 8'h04 && d <= 8'h07) m_id = d[1];
      else if (d >= 8'h08 && d <= 8'h0F) m_disp = d[2];
      else if (d >= 8'h80) m_ac = d[6:0];
   endfunction

   task automatic bus_xfer(input bit rs, input bit rw, input logic [7:0] d, input int hold,
                           output logic [7:0] rdata, output logic oe_hi);
      @(negedge clk);
      lcd_rs = rs; lcd_rw = rw; lcd_data_in = d;
      repeat (2) @(negedge clk);
      lcd_e = 1'b1;
      repeat (hold) @(negedge clk);
      rdata = lcd_data_out;
      oe_hi = lcd_data_oe;
      lcd_e = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic wr(input bit rs, input logic [7:0] d);
      logic [7:0] r; logic o;
      bus_xfer(rs, 1'b0, d, 16, r, o);
   endtask

   task automatic wait_ready(output logic [7:0] st);
      logic o;
      int n = 0;
      st = 8'hFF;
      while (n < 100) begin
         bus_xfer(1'b0, 1'b1, 8'h00, 16, st, o);
         if (st[7] == 1'b0) break;
         n++;
      end
      checks++;
      if (n >= 100) begin
         errors++;
         $display("FAIL wait_ready: BF still %b after %0d polls, required 0", st[7], n);
      end
   endtask

   task automatic write_poll(input bit rs, input logic [7:0] d, input string name);
      logic [7:0] st;
      wr(rs, d);
      model_write(rs, d);
      wait_ready(st);
      checks++;
      if (st !== {1'b0, m_ac}) begin
         errors++;
         $display("FAIL %s status: got %02h, expected %02h", name, st, {1'b0, m_ac});
      end
   endtask

   task automatic check_disp(input logic [6:0] a, input string name);
      disp_addr = a;
      repeat (2) @(negedge clk);
      checks++;
      if (disp_char !== m_ddram[a]) begin
         errors++;
         $display("FAIL %s disp_char[%02h]: got %02h, expected %02h", name, a, disp_char, m_ddram[a]);
      end
   endtask

   task automatic test_reset();
      logic [7:0] r; logic o;
      reset = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if ({lcd_data_out, lcd_data_oe, disp_char, display_on, busy} !== 19'h0) begin
         errors++;
         $display("FAIL reset_values: out=%02h oe=%b char=%02h don=%b busy=%b, expected all 0",
                  lcd_data_out, lcd_data_oe, disp_char, display_on, busy);
      end
      reset = 1'b0;
      m_ac = 7'h00; m_id = 1'b1; m_disp = 1'b0;
      repeat (3) @(negedge clk);
      bus_xfer(1'b0, 1'b1, 8'h00, 16, r, o);
      checks++;
      if (r !== 8'h00 || o !== 1'b1) begin
         errors++;
         $display("FAIL reset_status: data=%02h oe=%b, expected 00 and 1", r, o);
      end
      checks++;
      if (lcd_data_oe !== 1'b0) begin
         errors++;
         $display("FAIL oe_release: oe=%b after E low, expected 0", lcd_data_oe);
      end
`ifdef LCD_PROTOCOL_CHECK_EN
      checks++;
      if (protocol_err !== 1'b0) begin
         errors++;
         $display("FAIL perr_reset: got %b, expected 0", protocol_err);
      end
`endif
   endtask

   task automatic test_clear();
      logic [7:0] r; logic o;
      int t0 = busy_cnt;
      wr(1'b0, 8'h01);
      model_write(1'b0, 8'h01);
      bus_xfer(1'b0, 1'b1, 8'h00, 16, r, o);
      checks++;
      if (r[7] !== 1'b1) begin
         errors++;
         $display("FAIL clear_bf: status %02h, expected BF=1", r);
      end
      wait_ready(r);
      checks++;
      if (busy_cnt - t0 < CLEAR_C || busy_cnt - t0 > CLEAR_C + 2) begin
         errors++;
         $display("FAIL clear_busy_len: %0d cycles, expected %0d", busy_cnt - t0, CLEAR_C);
      end
      checks++;
      if (r !== 8'h00) begin
         errors++;
         $display("FAIL clear_status: got %02h, expected 00", r);
      end
      check_disp(7'h00, "clear");
      check_disp(7'h55, "clear");
      check_disp(7'h7F, "clear");
   endtask

   task automatic test_entry_wrap_up();
      write_poll(1'b0, 8'h06, "entry_inc");
      write_poll(1'b0, 8'hFE, "set_7e");
      write_poll(1'b1, 8'h41, "data_A");
      write_poll(1'b1, 8'h42, "data_B");
      write_poll(1'b1, 8'h43, "data_C");
      check_disp(7'h7E, "wrap_up");
      check_disp(7'h7F, "wrap_up");
      check_disp(7'h00, "wrap_up");
   endtask

   task automatic test_wrap_down();
      int t0;
      write_poll(1'b0, 8'h04, "entry_dec");
      write_poll(1'b0, 8'h80, "set_00");
      t0 = busy_cnt;
      write_poll(1'b1, 8'h5A, "data_Z");
      checks++;
      if (busy_cnt - t0 < BUSY_C || busy_cnt - t0 > BUSY_C + 2) begin
         errors++;
         $display("FAIL write_busy_len: %0d cycles, expected %0d", busy_cnt - t0, BUSY_C);
      end
      check_disp(7'h00, "wrap_down");
   endtask

   task automatic test_back_to_back();
      logic [7:0] st;
      wr(1'b1, 8'h50);
      wr(1'b1, 8'h51);
      model_write(1'b1, 8'h50);
      wait_ready(st);
      checks++;
      if (st !== {1'b0, m_ac}) begin
         errors++;
         $display("FAIL discard_status: got %02h, expected %02h", st, {1'b0, m_ac});
      end
      check_disp(7'h7F, "discard");
      check_disp(7'h7E, "discard");
`ifdef LCD_PROTOCOL_CHECK_EN
      checks++;
      if (protocol_err !== 1'b1) begin
         errors++;
         $display("FAIL perr_discard: got %b, expected 1", protocol_err);
      end
`endif
   endtask

   task automatic test_display();
      write_poll(1'b0, 8'h0C, "disp_on");
      checks++;
      if (display_on !== 1'b1) begin
         errors++;
         $display("FAIL display_on: got %b, expected 1", display_on);
      end
      write_poll(1'b0, 8'h08, "disp_off");
      checks++;
      if (display_on !== 1'b0) begin
         errors++;
         $display("FAIL display_off: got %b, expected 0", display_on);
      end
   endtask

   task automatic test_data_read();
      logic [7:0] r, st; logic o;
      write_poll(1'b0, 8'h06, "rd_entry");
      write_poll(1'b0, 8'h90, "rd_set");
      write_poll(1'b1, 8'h78, "rd_x");
      write_poll(1'b0, 8'h90, "rd_set2");
      bus_xfer(1'b1, 1'b1, 8'h00, 16, r, o);
      checks++;
      if (r !== 8'h78 || o !== 1'b1) begin
         errors++;
         $display("FAIL data_read: data=%02h oe=%b, expected 78 and 1", r, o);
      end
      m_ac = m_next(m_ac);
      wait_ready(st);
      checks++;
      if (st !== 8'h11) begin
         errors++;
         $display("FAIL data_read_ac: status %02h, expected 11", st);
      end
   endtask

   task automatic test_random();
      logic [7:0] r, st, d; logic o;
      int op;
      for (int it = 0; it < 60; it++) begin
         op = $urandom_range(0, 7);
         case (op)
            0, 1: write_poll(1'b1, 8'($urandom), "rnd_data");
            2:    write_poll(1'b0, 8'h80 | 8'($urandom_range(0, 127)), "rnd_setaddr");
            3:    write_poll(1'b0, 8'h04 | 8'($urandom_range(0, 3)), "rnd_entry");
            4: begin
               d = 8'($urandom_range(16, 127));
               write_poll(1'b0, d, "rnd_nochange");
            end
            5: begin
               d = 8'h08 | 8'($urandom_range(0, 7));
               write_poll(1'b0, d, "rnd_disp");
               checks++;
               if (display_on !== m_disp) begin
                  errors++;
                  $display("FAIL rnd_display_on: got %b, expected %b", display_on, m_disp);
               end
            end
            6: begin
               bus_xfer(1'b1, 1'b1, 8'h00, 16, r, o);
               checks++;
               if (r !== m_ddram[m_ac]) begin
                  errors++;
                  $display("FAIL rnd_read at %02h: got %02h, expected %02h", m_ac, r, m_ddram[m_ac]);
               end
               m_ac = m_next(m_ac);
               wait_ready(st);
               checks++;
               if (st !== {1'b0, m_ac}) begin
                  errors++;
                  $display("FAIL rnd_read_ac: got %02h, expected %02h", st, {1'b0, m_ac});
               end
            end
            default: check_disp(7'($urandom_range(0, 127)), "rnd_overlay");
         endcase
      end
   endtask

`ifdef LCD_PROTOCOL_CHECK_EN
   task automatic test_short_pulse();
      logic [7:0] r; logic o;
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (protocol_err !== 1'b0) begin
         errors++;
         $display("FAIL perr_clear: got %b, expected 0", protocol_err);
      end
      bus_xfer(1'b0, 1'b0, 8'h0C, 4, r, o);
      checks++;
      if (protocol_err !== 1'b1 || display_on !== 1'b1) begin
         errors++;
         $display("FAIL short_pulse: perr=%b don=%b, expected 1 and 1", protocol_err, display_on);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_clear();
      test_entry_wrap_up();
      test_wrap_down();
      test_back_to_back();
      test_display();
      test_data_read();
      test_random();
`ifdef LCD_PROTOCOL_CHECK_EN
      test_short_pulse();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
